// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between the command/data path and the UART transmitter.
//   tx_data   8  byte to send, sampled on the edge where tx_valid && tx_ready
//   tx_valid  1  source holds a byte in tx_data
//   tx_ready  1  transmitter holding register empty, a byte can be accepted
// Modports: master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter for the board serial link. Bytes arrive over a
// valid/ready handshake. A one-entry holding register lets the next byte wait
// while the current frame is on the line, so frames can run back to back with
// no idle gap. Bits go out LSB first, each lasting BIT_PERIOD clocks.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data bits and the stop bit (8E1 when PARITY_ODD=0, 8O1 when 1).
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   bus      slave     tx_data / tx_valid / tx_ready handshake (uart_tx_if)
//   tx       out  1  serial line, idle high
//   tx_busy  out  1  a frame is on the line (start bit through stop bit)
//   tx_done  out  1  one-clock pulse in the last clock of each stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam int          BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] BIT_LAST   = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] BIT_PENULT = 16'(BIT_PERIOD - 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift_q, shift_n;
    logic [7:0]  hold_q, hold_n;
    logic        ready_q, ready_n;     // high = holding register empty
    logic        tx_n, busy_n, done_n;
    logic        load;
    logic [7:0]  load_byte;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_n;
`endif

    logic accept;
    logic bit_end;

    assign accept       = bus.tx_valid && ready_q;
    assign bit_end      = (cnt == BIT_LAST);
    assign bus.tx_ready = ready_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift_q;
        hold_n    = hold_q;
        ready_n   = ready_q;
        tx_n      = tx;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        load      = 1'b0;
        load_byte = hold_q;
`ifdef UART_TX_PARITY_EN
        par_n     = par_q;
`endif

        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (!ready_q) begin
                    load      = 1'b1;
                    load_byte = hold_q;
                    ready_n   = 1'b1;
                end else if (accept) begin
                    // Idle line: the byte goes straight into the shifter.
                    load      = 1'b1;
                    load_byte = bus.tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    tx_n    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par_q;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        shift_n = {1'b0, shift_q[7:1]};
                        idx_n   = idx + 3'd1;
                        tx_n    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                // tx_done is registered, so raise it one clock early.
                if (cnt == BIT_PENULT) begin
                    done_n = 1'b1;
                end
                if (bit_end) begin
                    if (!ready_q) begin
                        load      = 1'b1;
                        load_byte = hold_q;
                        ready_n   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (load) begin
            state_n = START;
            cnt_n   = '0;
            shift_n = load_byte;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_n   = (^load_byte) ^ PARITY_ODD;
`endif
        end

        // Outside IDLE an accepted byte waits in the holding register; this
        // also covers a handshake on the same edge the register drains.
        if (accept && (state != IDLE)) begin
            hold_n  = bus.tx_data;
            ready_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            ready_q <= 1'b1;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            ready_q <= ready_n;
            tx      <= tx_n;
            tx_busy <= busy_n;
            tx_done <= done_n;
        end
    end

    // Data-only registers; their contents are ignored until reloaded.
    always_ff @(posedge clk) begin
        shift_q <= shift_n;
        hold_q  <= hold_n;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_n;
`endif
    end
endmodule
